// File: rtl/lifo.sv
// Synchronous LIFO stack: push/pop on a single clock, registered pop data,
// occupancy counter doubles as the stack pointer.
module lifo #(
  parameter int unsigned DEPTH      = 12,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_wr,
  input  logic                  wr_en,
  output logic                  lifo_full,
  output logic [DATA_WIDTH-1:0] data_rd,
  input  logic                  rd_en,
  output logic                  lifo_empty
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [CW-1:0]         r_count;
  logic [DATA_WIDTH-1:0] r_data_rd;

  logic          w_empty;
  logic          w_full;
  logic          w_push;
  logic          w_pop;
  logic          w_replace;
  logic [AW-1:0] w_top_idx;
  logic [AW-1:0] w_free_idx;
  logic [CW-1:0] w_count_nxt;

  assign w_empty    = (r_count == CW'(0));
  assign w_full     = (r_count == CW'(DEPTH));
  assign lifo_empty = w_empty;
  assign lifo_full  = w_full;
  assign data_rd    = r_data_rd;

  // A simultaneous push/pop on a non-empty stack replaces the top entry,
  // even when full; on an empty stack it degrades to a plain push.
  assign w_replace  = wr_en && rd_en && !w_empty;
  assign w_push     = wr_en && !w_full && !(rd_en && !w_empty);
  assign w_pop      = rd_en && !wr_en && !w_empty;

  assign w_top_idx  = AW'(r_count - CW'(1));
  assign w_free_idx = AW'(r_count);

  // Next occupancy; saturation falls out of the accept conditions above.
  always_comb begin
    w_count_nxt = r_count;
    if (w_push) begin
      w_count_nxt = r_count + CW'(1);
    end else if (w_pop) begin
      w_count_nxt = r_count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count   <= '0;
      r_data_rd <= '0;
    end else begin
      r_count <= w_count_nxt;
      if (w_pop || w_replace) begin
        r_data_rd <= r_mem[w_top_idx];
      end
    end
  end

  // Storage is never cleared; reset only blocks writes on its own edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (w_push) begin
        r_mem[w_free_idx] <= data_wr;
      end else if (w_replace) begin
        r_mem[w_top_idx] <= data_wr;
      end
    end
  end

endmodule

// File: tb/tb_lifo.sv
// Scoreboard bench for lifo: stimulus queues per-edge expectations, a monitor
// compares data_rd and both flags 1 ns after every rising edge.
module tb_lifo;

  localparam int unsigned DEPTH = 12;
  localparam int unsigned DW    = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] data_wr = '0;
  logic          wr_en = 1'b0;
  logic          rd_en = 1'b0;
  logic          lifo_full;
  logic          lifo_empty;
  logic [DW-1:0] data_rd;

  typedef struct {
    logic [DW-1:0] d;
    logic          e;
    logic          f;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  logic [DW-1:0] stk[$];
  logic [DW-1:0] last_rd;

  lifo #(.DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .data_wr    (data_wr),
    .wr_en      (wr_en),
    .lifo_full  (lifo_full),
    .data_rd    (data_rd),
    .rd_en      (rd_en),
    .lifo_empty (lifo_empty)
  );

  always #5 clk = ~clk;

  // Monitor: one queued expectation per rising edge.
  always begin
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_cmp++;
      if (data_rd !== e.d) begin
        n_err++;
        $display("FAIL data_rd @%0t: got %02h expected %02h", $time, data_rd, e.d);
      end
      n_cmp++;
      if (lifo_empty !== e.e) begin
        n_err++;
        $display("FAIL lifo_empty @%0t: got %b expected %b", $time, lifo_empty, e.e);
      end
      n_cmp++;
      if (lifo_full !== e.f) begin
        n_err++;
        $display("FAIL lifo_full @%0t: got %b expected %b", $time, lifo_full, e.f);
      end
    end
  end

  task automatic step(input logic r, input logic w, input logic [DW-1:0] d,
                      input logic p, input logic [DW-1:0] ed,
                      input logic ee, input logic ef);
    exp_t e;
    @(negedge clk);
    rst     = r;
    wr_en   = w;
    data_wr = d;
    rd_en   = p;
    e.d = ed;
    e.e = ee;
    e.f = ef;
    exp_q.push_back(e);
  endtask

  // Reference stack used only for the random phase.
  task automatic rnd_step(input logic w, input logic [DW-1:0] d, input logic p);
    if (w && p && stk.size() > 0) begin
      last_rd = stk[$];
      stk[stk.size()-1] = d;
    end else if (w && (!p || stk.size() == 0)) begin
      if (stk.size() < DEPTH) stk.push_back(d);
    end else if (p && stk.size() > 0) begin
      last_rd = stk.pop_back();
    end
    step(1'b0, w, d, p, last_rd, stk.size() == 0, stk.size() == DEPTH);
  endtask

  initial begin
    // Reset held for 5 edges, then an idle edge.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0);

    // Push 11,22,33 then pop three times.
    step(1'b0, 1'b1, 8'h11, 1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'h22, 1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'h33, 1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b1, 8'h33, 1'b0, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b1, 8'h22, 1'b0, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b1, 8'h11, 1'b1, 1'b0);

    // Fill with 1..12, overflow push of AA is dropped.
    for (int i = 1; i <= 12; i++)
      step(1'b0, 1'b1, 8'(i), 1'b0, 8'h11, 1'b0, i == 12);
    step(1'b0, 1'b1, 8'hAA, 1'b0, 8'h11, 1'b0, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b1, 8'd12, 1'b0, 1'b0);
    for (int i = 11; i >= 1; i--)
      step(1'b0, 1'b0, 8'h00, 1'b1, 8'(i), i == 1, 1'b0);

    // Underflow: pops from empty hold data_rd.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'h00, 1'b1, 8'd1, 1'b1, 1'b0);

    // Simultaneous push/pop on {5,9} replaces the top.
    step(1'b0, 1'b1, 8'h05, 1'b0, 8'd1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'h09, 1'b0, 8'd1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'h40, 1'b1, 8'h09, 1'b0, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b1, 8'h40, 1'b0, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b1, 8'h05, 1'b1, 1'b0);

    // Simultaneous push/pop on empty acts as a push.
    step(1'b0, 1'b1, 8'h77, 1'b1, 8'h05, 1'b0, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b1, 8'h77, 1'b1, 1'b0);

    // Simultaneous push/pop on a full stack replaces the top.
    for (int i = 1; i <= 12; i++)
      step(1'b0, 1'b1, 8'(8'h80 + i), 1'b0, 8'h77, 1'b0, i == 12);
    step(1'b0, 1'b1, 8'h5A, 1'b1, 8'h8C, 1'b0, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b1, 8'h5A, 1'b0, 1'b0);

    // Mid-operation reset discards everything.
    step(1'b1, 1'b1, 8'hEE, 1'b1, 8'h00, 1'b1, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0);

    // Random bursts against the reference stack.
    last_rd = 8'h00;
    for (int b = 0; b < 120; b++) begin
      int op;
      int n;
      op = $urandom_range(0, 4);
      n  = $urandom_range(1, 3);
      for (int k = 0; k < n; k++) begin
        logic [DW-1:0] d;
        d = 8'($urandom);
        case (op)
          0, 1:    rnd_step(1'b1, d, 1'b0);
          2, 3:    rnd_step(1'b0, d, 1'b1);
          default: rnd_step(1'b1, d, 1'b1);
        endcase
      end
    end
    step(1'b0, 1'b0, 8'h00, 1'b0, last_rd, stk.size() == 0, stk.size() == DEPTH);

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    #3;
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/lifo.md
Name: lifo

Overview:
- Synchronous last-in-first-out stack, parameterised in depth and data width, on a single clock.
- Push port with a full flag; pop port with a registered read-data output and an empty flag.
- Used as a general buffering primitive wherever the most recently written item must be consumed first.

Parameters:
- DEPTH, 12, number of storage entries (>=2).
- DATA_WIDTH, 8, bit width of each entry.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  reset: synchronous and active-high. Clears the stack on a clk rising edge while high.
- data_wr  input  DATA_WIDTH  data pushed when wr_en is accepted.
- wr_en  input  1  push request, sampled on rising clk.
- lifo_full  output  1  high when the stack holds DEPTH entries.
- data_rd  output  DATA_WIDTH  registered pop data.
- rd_en  input  1  pop request, sampled on rising clk.
- lifo_empty  output  1  high when the stack holds 0 entries.

Behaviour:
- State:
  - Storage array of DEPTH x DATA_WIDTH.
  - Occupancy counter `count`, width $clog2(DEPTH+1), range 0..DEPTH. It also serves as the stack pointer: the next free slot is index `count` and the top of the stack is index `count-1`.
- Reset (rst high at a clk edge):
  - count=0 and data_rd=0, so lifo_empty=1 and lifo_full=0.
  - Storage contents are not cleared.
  - rst overrides any simultaneous wr_en or rd_en.
  - A reset mid-operation discards all entries.
- Flags:
  - lifo_empty = (count==0) and lifo_full = (count==DEPTH).
  - Both are decoded from the registered count, with no extra cycle of latency. They reflect the state after the most recent clk edge and are valid 1 ns after that edge.
- Push only (wr_en=1, rd_en=0):
  - If not full: mem[count] <= data_wr and count <= count+1.
  - If full: the write is dropped and state is unchanged.
- Pop only (rd_en=1, wr_en=0):
  - If not empty: data_rd <= mem[count-1] and count <= count-1. The popped value appears on data_rd right after the same edge (1-edge latency from rd_en sampled).
  - If empty: the pop is ignored; data_rd and count are unchanged.
- Simultaneous push and pop:
  - If not empty (including full): data_rd <= mem[count-1], then mem[count-1] <= data_wr. count is unchanged; the top entry is replaced.
  - If empty: treated as a push only; data_rd holds.
- Hold: data_rd keeps its last value whenever no pop is accepted.
- Back-to-back: pushes and pops are accepted on every cycle with no bubbles. Consecutive pops return entries in strict reverse write order.
- No overflow or underflow wrap: count saturates at 0 and DEPTH by the ignore rules above.

Test Plan:
- Reset: hold rst=1 for 5 cycles, then release -> lifo_empty=1, lifo_full=0, data_rd=0.
- Push then pop: push 0x11, 0x22, 0x33 on consecutive cycles, then hold rd_en for 3 cycles -> data_rd = 0x33, 0x22, 0x11 on successive edges; lifo_empty=1 after the third pop; lifo_full stays 0 throughout.
- Fill and overflow: push 12 values 1..12, then push 0xAA -> lifo_full=1 after the 12th push; 0xAA is dropped; the next pop returns 12 and lifo_full then deasserts.
- Underflow: pop 3 times from empty -> lifo_empty stays 1, count stays 0, data_rd holds its previous value.
- Simultaneous push and pop:
  - With stack {5,9} (top 9), assert wr_en=1, data_wr=0x40, rd_en=1 for one edge -> data_rd=9 and count stays 2; the following pop returns 0x40.
  - The same stimulus on an empty stack -> count=1 and data_rd unchanged.
- Random mix: random bursts of 1-3 pushes and pops with random data, checked against a reference stack model -> every popped value matches the model top; lifo_full and lifo_empty match the model occupancy (12 and 0) after every edge.
